// File: rtl/mips_alu_pkg.sv
// Shared ALU definitions for the MIPS core: op codes, operand-source selects,
// datapath width and the leading-bit counter used by CLZ/CLO.
package mips_alu_pkg;

  localparam int WIDTH = 32;

  localparam logic ALU_SRC_IM = 1'b0;
  localparam logic ALU_SRC_RT = 1'b1;

  localparam logic [5:0] ALU_OP_ADD   = 6'd0;
  localparam logic [5:0] ALU_OP_ADDU  = 6'd1;
  localparam logic [5:0] ALU_OP_SUB   = 6'd2;
  localparam logic [5:0] ALU_OP_SUBU  = 6'd3;
  localparam logic [5:0] ALU_OP_AND   = 6'd4;
  localparam logic [5:0] ALU_OP_OR    = 6'd5;
  localparam logic [5:0] ALU_OP_XOR   = 6'd6;
  localparam logic [5:0] ALU_OP_NOR   = 6'd7;
  localparam logic [5:0] ALU_OP_SLT   = 6'd8;
  localparam logic [5:0] ALU_OP_SLTU  = 6'd9;
  localparam logic [5:0] ALU_OP_SLL   = 6'd10;
  localparam logic [5:0] ALU_OP_SRL   = 6'd11;
  localparam logic [5:0] ALU_OP_SRA   = 6'd12;
  localparam logic [5:0] ALU_OP_SLLV  = 6'd13;
  localparam logic [5:0] ALU_OP_SRLV  = 6'd14;
  localparam logic [5:0] ALU_OP_SRAV  = 6'd15;
  localparam logic [5:0] ALU_OP_LUI   = 6'd16;
  localparam logic [5:0] ALU_OP_MULT  = 6'd17;
  localparam logic [5:0] ALU_OP_MULTU = 6'd18;
  localparam logic [5:0] ALU_OP_DIV   = 6'd19;
  localparam logic [5:0] ALU_OP_DIVU  = 6'd20;
  localparam logic [5:0] ALU_OP_MFHI  = 6'd21;
  localparam logic [5:0] ALU_OP_MFLO  = 6'd22;
  localparam logic [5:0] ALU_OP_MTHI  = 6'd23;
  localparam logic [5:0] ALU_OP_MTLO  = 6'd24;
  localparam logic [5:0] ALU_OP_CLZ   = 6'd25;
  localparam logic [5:0] ALU_OP_CLO   = 6'd26;
  localparam logic [5:0] ALU_OP_EXT   = 6'd27;
  localparam logic [5:0] ALU_OP_INS   = 6'd28;
  localparam logic [5:0] ALU_OP_MUL   = 6'd29;
  localparam logic [5:0] ALU_OP_ROTR  = 6'd30;
  localparam logic [5:0] ALU_OP_ROTRV = 6'd31;

  // Counts how many bits from the MSB down equal val (0..32).
  function automatic logic [5:0] lead_count(input logic [31:0] v, input logic val);
    logic [5:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      if (run && (v[i] == val)) n = n + 6'd1;
      else                      run = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/mips_alu_hilo.sv
// HI/LO register pair with multiplier and divider; only built when
// MIPS_ALU_MULDIV_EN is defined.
`ifdef MIPS_ALU_MULDIV_EN
module mips_alu_hilo
  import mips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, mag_q, mag_r, quot_s, rem_s, quot_u, rem_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
  assign abs_a  = a[31] ? (~a + 32'd1) : a;
  assign abs_b  = b[31] ? (~b + 32'd1) : b;
  assign mag_q  = abs_a / abs_b;
  assign mag_r  = abs_a % abs_b;
  assign quot_s = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
  assign rem_s  = a[31] ? (~mag_r + 32'd1) : mag_r;
  assign quot_u = a / b;
  assign rem_u  = a % b;

  // NOTE: reset is asynchronous, so an asserted rst overrides any write due this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      case (alu_op)
        ALU_OP_MULT:  {hi, lo} <= prod_s;
        ALU_OP_MULTU: {hi, lo} <= prod_u;
        ALU_OP_DIV:   if (b != '0) begin
                        lo <= quot_s;
                        hi <= rem_s;
                      end
        ALU_OP_DIVU:  if (b != '0) begin
                        lo <= quot_u;
                        hi <= rem_u;
                      end
        ALU_OP_MTHI:  hi <= a;
        ALU_OP_MTLO:  lo <= a;
        default:      ;
      endcase
    end
  end

endmodule
`endif

// File: rtl/mips_alu.sv
// 32-bit MIPS ALU: combinational datapath plus branch/overflow flags.
// Define MIPS_ALU_MULDIV_EN to include HI/LO, MULT/DIV and MUL support.
module mips_alu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  input  logic [4:0]       ins15_11,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             great,
  output logic             overflow
);

  logic [31:0] hi, lo, mul_lo;

`ifdef MIPS_ALU_MULDIV_EN
  mips_alu_hilo u_hilo (
    .clk    (clk),
    .rst    (rst),
    .alu_op (alu_op),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo)
  );
  assign mul_lo = a * b;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst};
  assign hi        = '0;
  assign lo        = '0;
  assign mul_lo    = '0;
`endif

  logic [31:0] sum, diff, ext_mask, ins_mask;
  logic [63:0] rot_i, rot_v;

  assign sum      = a + b;
  assign diff     = a - b;
  assign rot_i    = {b, b} >> shamt;
  assign rot_v    = {b, b} >> a[4:0];
  assign ext_mask = 32'hFFFF_FFFF >> (5'd31 - ins15_11);
  assign ins_mask = (32'hFFFF_FFFF >> (5'd31 - ins15_11)) & (32'hFFFF_FFFF << shamt);

  assign zero  = (a == b);
  assign great = ($signed(a) > $signed(b));

  always_comb begin
    overflow = 1'b0;
    case (alu_op)
      ALU_OP_ADD: overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      ALU_OP_SUB: overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      default:    overflow = 1'b0;
    endcase
  end

  // NOTE: every path assigns out (default first), so no latch is inferred.
  always_comb begin
    out = '0;
    case (alu_op)
      ALU_OP_ADD, ALU_OP_ADDU: out = sum;
      ALU_OP_SUB, ALU_OP_SUBU: out = diff;
      ALU_OP_AND:   out = a & b;
      ALU_OP_OR:    out = a | b;
      ALU_OP_XOR:   out = a ^ b;
      ALU_OP_NOR:   out = ~(a | b);
      ALU_OP_SLT:   out = {31'b0, $signed(a) < $signed(b)};
      ALU_OP_SLTU:  out = {31'b0, a < b};
      ALU_OP_SLL:   out = b << shamt;
      ALU_OP_SRL:   out = b >> shamt;
      ALU_OP_SRA:   out = $signed(b) >>> shamt;
      ALU_OP_SLLV:  out = b << a[4:0];
      ALU_OP_SRLV:  out = b >> a[4:0];
      ALU_OP_SRAV:  out = $signed(b) >>> a[4:0];
      ALU_OP_LUI:   out = b << 16;
      ALU_OP_MFHI:  out = hi;
      ALU_OP_MFLO:  out = lo;
      ALU_OP_CLZ:   out = {26'b0, lead_count(a, 1'b0)};
      ALU_OP_CLO:   out = {26'b0, lead_count(a, 1'b1)};
      ALU_OP_EXT:   out = (a >> shamt) & ext_mask;
      ALU_OP_INS:   out = (ins15_11 < shamt) ? b : ((b & ~ins_mask) | ((a << shamt) & ins_mask));
      ALU_OP_MUL:   out = mul_lo;
      ALU_OP_ROTR:  out = rot_i[31:0];
      ALU_OP_ROTRV: out = rot_v[31:0];
      default:      out = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: the driver queues hand-computed results,
// the monitor pops and compares each time a vector is presented.
module tb_mips_alu;
  import mips_alu_pkg::*;

`ifdef MIPS_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] out;
    logic [2:0]  flags;  // {zero, great, overflow}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  alu_op = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  shamt = '0, ins15_11 = '0;
  logic [31:0] alu_out;
  logic        zero, great, overflow;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  event sample_ev;

  mips_alu dut (
    .clk      (clk),
    .rst      (rst),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .ins15_11 (ins15_11),
    .out      (alu_out),
    .zero     (zero),
    .great    (great),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] md(input logic [31:0] v);
    return MD ? v : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push(input string name, input logic [31:0] eo, input logic [2:0] ef);
    exp_t e;
    e.name  = name;
    e.out   = eo;
    e.flags = ef;
    sb_q.push_back(e);
  endtask

  task automatic vec(input string name, input logic [5:0] op, input logic [31:0] va,
                     input logic [31:0] vb, input logic [4:0] sh, input logic [4:0] ins,
                     input logic [31:0] eo, input logic [2:0] ef);
    @(posedge clk);
    #1;
    alu_op   = op;
    a        = va;
    b        = vb;
    shamt    = sh;
    ins15_11 = ins;
    push(name, eo, ef);
    @(negedge clk);
    ->sample_ev;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got no entry expected one");
      end else begin
        e = sb_q.pop_front();
        check(e.name, alu_out, e.out);
        check({e.name, "_flags"}, {29'b0, zero, great, overflow}, {29'b0, e.flags});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    #12 rst = 1'b0;
    vec("reset_hi",   ALU_OP_MFHI,  32'h0,        32'h0,        5'd0, 5'd0, 32'h0,        3'b100);
    vec("reset_lo",   ALU_OP_MFLO,  32'h0,        32'h0,        5'd0, 5'd0, 32'h0,        3'b100);
    vec("add_ovf",    ALU_OP_ADD,   32'h7FFFFFFF, 32'h1,        5'd0, 5'd0, 32'h80000000, 3'b011);
    vec("addu",       ALU_OP_ADDU,  32'h7FFFFFFF, 32'h1,        5'd0, 5'd0, 32'h80000000, 3'b010);
    vec("sub_ovf",    ALU_OP_SUB,   32'h80000000, 32'h1,        5'd0, 5'd0, 32'h7FFFFFFF, 3'b001);
    vec("slt",        ALU_OP_SLT,   32'hFFFFFFFF, 32'h1,        5'd0, 5'd0, 32'h1,        3'b000);
    vec("sltu",       ALU_OP_SLTU,  32'hFFFFFFFF, 32'h1,        5'd0, 5'd0, 32'h0,        3'b000);
    vec("sra",        ALU_OP_SRA,   32'h0,        32'h80000000, 5'd4, 5'd0, 32'hF8000000, 3'b010);
    vec("rotr",       ALU_OP_ROTR,  32'h0,        32'h1,        5'd1, 5'd0, 32'h80000000, 3'b000);
    vec("rotrv",      ALU_OP_ROTRV, 32'h4,        32'h000000F1, 5'd0, 5'd0, 32'h1000000F, 3'b000);
    vec("clz_mid",    ALU_OP_CLZ,   32'h00010000, 32'h0,        5'd0, 5'd0, 32'd15,       3'b010);
    vec("clz_zero",   ALU_OP_CLZ,   32'h0,        32'h0,        5'd0, 5'd0, 32'd32,       3'b100);
    vec("clo",        ALU_OP_CLO,   32'hFFFF0000, 32'h0,        5'd0, 5'd0, 32'd16,       3'b000);
    vec("clo_all",    ALU_OP_CLO,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0, 32'd32,       3'b100);
    vec("ext",        ALU_OP_EXT,   32'hABCD1234, 32'h0,        5'd8, 5'd7, 32'h12,       3'b000);
    vec("ins",        ALU_OP_INS,   32'hF,        32'h0,        5'd4, 5'd7, 32'hF0,       3'b010);
    vec("ins_inv",    ALU_OP_INS,   32'hF,        32'h55,       5'd8, 5'd4, 32'h55,       3'b000);
    vec("xor",        ALU_OP_XOR,   32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 5'd0, 32'hF00FF00F, 3'b000);
    vec("nor",        ALU_OP_NOR,   32'h0,        32'h0,        5'd0, 5'd0, 32'hFFFFFFFF, 3'b100);
    vec("lui",        ALU_OP_LUI,   32'h0,        32'h1234,     5'd0, 5'd0, 32'h12340000, 3'b000);
    vec("srlv",       ALU_OP_SRLV,  32'h4,        32'h80000000, 5'd0, 5'd0, 32'h08000000, 3'b010);
    vec("bad_op",     6'd40,        32'h5,        32'h5,        5'd0, 5'd0, 32'h0,        3'b100);
    vec("mul",        ALU_OP_MUL,   32'hFFFFFFFE, 32'h3,        5'd0, 5'd0, md(32'hFFFFFFFA), 3'b000);
    vec("mult",       ALU_OP_MULT,  32'hFFFFFFFE, 32'h3,        5'd0, 5'd0, 32'h0,        3'b000);
    vec("mult_hi",    ALU_OP_MFHI,  32'h0,        32'h0,        5'd0, 5'd0, md(32'hFFFFFFFF), 3'b100);
    vec("mult_lo",    ALU_OP_MFLO,  32'h0,        32'h0,        5'd0, 5'd0, md(32'hFFFFFFFA), 3'b100);
    vec("div",        ALU_OP_DIV,   32'hFFFFFFF9, 32'h2,        5'd0, 5'd0, 32'h0,        3'b000);
    vec("div_lo",     ALU_OP_MFLO,  32'h0,        32'h0,        5'd0, 5'd0, md(32'hFFFFFFFD), 3'b100);
    vec("div_hi",     ALU_OP_MFHI,  32'h0,        32'h0,        5'd0, 5'd0, md(32'hFFFFFFFF), 3'b100);
    vec("div_min",    ALU_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0,        3'b000);
    vec("div_min_lo", ALU_OP_MFLO,  32'h0,        32'h0,        5'd0, 5'd0, md(32'h80000000), 3'b100);
    vec("div_min_hi", ALU_OP_MFHI,  32'h0,        32'h0,        5'd0, 5'd0, 32'h0,        3'b100);
    vec("multu",      ALU_OP_MULTU, 32'hFFFFFFFF, 32'h2,        5'd0, 5'd0, 32'h0,        3'b000);
    vec("multu_hi",   ALU_OP_MFHI,  32'h0,        32'h0,        5'd0, 5'd0, md(32'h1),    3'b100);
    vec("mthi",       ALU_OP_MTHI,  32'h1234,     32'h0,        5'd0, 5'd0, 32'h0,        3'b010);
    vec("divu_zero",  ALU_OP_DIVU,  32'h5,        32'h0,        5'd0, 5'd0, 32'h0,        3'b010);
    vec("hi_kept",    ALU_OP_MFHI,  32'h0,        32'h0,        5'd0, 5'd0, md(32'h1234), 3'b100);
    vec("mtlo",       ALU_OP_MTLO,  32'h99,       32'h99,       5'd0, 5'd0, 32'h0,        3'b100);
    vec("lo_set",     ALU_OP_MFLO,  32'h0,        32'h0,        5'd0, 5'd0, md(32'h99),   3'b100);
    vec("divu",       ALU_OP_DIVU,  32'd17,       32'd5,        5'd0, 5'd0, 32'h0,        3'b010);
    vec("divu_hi",    ALU_OP_MFHI,  32'h0,        32'h0,        5'd0, 5'd0, md(32'd2),    3'b100);
    vec("divu_lo",    ALU_OP_MFLO,  32'h0,        32'h0,        5'd0, 5'd0, md(32'd3),    3'b100);
    vec("mthi2",      ALU_OP_MTHI,  32'h1234,     32'h0,        5'd0, 5'd0, 32'h0,        3'b010);
    vec("pre_rst_hi", ALU_OP_MFHI,  32'h0,        32'h0,        5'd0, 5'd0, md(32'h1234), 3'b100);
    // Async reset between edges: HI must clear with no clock edge.
    #2 rst = 1'b1;
    #1;
    push("rst_hi", 32'h0, 3'b100);
    ->sample_ev;
    #1 rst = 1'b0;
    vec("rst_lo",     ALU_OP_MFLO,  32'h0,        32'h0,        5'd0, 5'd0, 32'h0,        3'b100);
    @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit integer ALU for the single-cycle MIPS core.
- Combinational datapath: arithmetic, logic, shift, compare, bit-field and count ops on operands a and b.
- Owns the HI/LO register pair, written by mult/div/move ops on the clock edge.
- Drives the zero/great branch flags to the PC unit and a signed-overflow flag.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  core clock; HI/LO update on rising edge.
- rst  input  1  asynchronous, active-high reset; clears HI/LO.
- alu_op  input  6  operation code from the shared package.
- a  input  32  operand 1, always [rs].
- b  input  32  operand 2, extended immediate or [rt] (0 for branch-vs-zero).
- shamt  input  5  instruction bits [10:6]: shift amount, or EXT/INS lsb.
- ins15_11  input  5  instruction bits [15:11]: EXT msbd / INS msb.
- out  output  32  result.
- zero  output  1  a == b.
- great  output  1  signed a > signed b.
- overflow  output  1  signed overflow on ADD/SUB.

Behaviour:
- zero and great: combinational on every op, independent of alu_op.
- overflow: 1 only for ADD or SUB with two's-complement overflow; otherwise 0. out still carries the wrapped result.
- Op codes and results (out, all combinational):
  - 0 ADD, 1 ADDU: a+b.
  - 2 SUB, 3 SUBU: a-b.
  - 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLT: signed a<b → 1/0. 9 SLTU: unsigned a<b → 1/0.
  - 10 SLL: b<<shamt. 11 SRL: logical shift right by shamt. 12 SRA: arithmetic shift right by shamt.
  - 13 SLLV, 14 SRLV, 15 SRAV: as 10-12, amount = a[4:0].
  - 16 LUI: b<<16.
  - 17 MULT, 18 MULTU, 19 DIV, 20 DIVU: out=0.
  - 21 MFHI: HI. 22 MFLO: LO.
  - 23 MTHI, 24 MTLO: out=0.
  - 25 CLZ: count of leading zeros of a, 0..32. 26 CLO: count of leading ones of a, 0..32.
  - 27 EXT: (a>>shamt) masked to ins15_11+1 bits.
  - 28 INS: b with bits [ins15_11:shamt] replaced by a[ins15_11-shamt:0]. If ins15_11<shamt, out=b.
  - 29 MUL: low 32 bits of signed a*b; HI/LO untouched.
  - 30 ROTR: rotate b right by shamt. 31 ROTRV: rotate b right by a[4:0].
  - All other codes: out=0.
- HI/LO writes, on rising clk:
  - MULT/MULTU: {HI,LO} <= 64-bit signed/unsigned product.
  - DIV/DIVU: LO <= quotient, HI <= remainder, signed/unsigned. Signed results truncate toward zero; remainder takes the sign of the dividend.
  - Divide by zero: HI/LO unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - MTHI: HI <= a. MTLO: LO <= a.
- MFHI/MFLO return the pre-edge value; an MTHI and a following MFHI see the new value one cycle later.
- Reset: HI=LO=0 immediately on rst assertion; a rst asserted mid-operation wins over any pending write.
- out, zero, great, overflow have no reset value; they are pure functions of the inputs.

Optional Feature:
- Macro MIPS_ALU_MULDIV_EN.
- Defined: ops 17-24 and 29 behave as above, with HI/LO registers present.
- Undefined: no HI/LO registers, no multiplier/divider; ops 17-24 and 29 give out=0. clk and rst remain ports but are unused.

Decomposition:
- Shared package mips_alu_pkg: the 6-bit ALU_OP_* constants (also used by the control decoder), ALU_SRC_IM/ALU_SRC_RT and WIDTH.
- One sub-module: mips_alu_hilo.
  - Contains the HI/LO registers, multiplier and divider.
  - Inputs: clk, rst, alu_op, a, b. Outputs: hi, lo.
  - Compiled only under MIPS_ALU_MULDIV_EN.

Test Plan:
- ADD a=0x7FFFFFFF b=1 → out=0x80000000, overflow=1. ADDU same operands → overflow=0.
- SLT a=0xFFFFFFFF b=1 → out=1. SLTU same → out=0. Same inputs: zero=0, great=0.
- SRA b=0x80000000 shamt=4 → 0xF8000000. ROTR b=0x00000001 shamt=1 → 0x80000000. CLZ a=0x00010000 → 15. CLZ a=0 → 32.
- MULT a=0xFFFFFFFE (-2) b=3, one clk → MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA. DIV a=-7 b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with b=0 after MTHI a=0x1234 → HI still 0x1234. rst pulse mid-sequence → HI=LO=0 without a clock edge.
- EXT a=0xABCD1234 shamt=8 ins15_11=7 → 0x12. INS a=0xF b=0 shamt=4 ins15_11=7 → 0xF0.
